// File: rtl/seg7_debug_display.sv
// Snapshots the processor's PC and write-back debug words and scans their low 16 bits
// onto an 8-digit common-anode seven-segment display (PC on digits 7..4, data on 3..0).
module seg7_debug_display #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCDisplay,
    input  logic [31:0] WriteDataDisplay,
    input  logic        Hold,
    output logic [7:0]  An,
    output logic [6:0]  Seg,
    output logic        Dp,
    output logic        Changed
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

    logic [63:0]     r_snap;
    logic            r_changed;
    logic [CntW-1:0] r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_an;
    logic [6:0]      r_seg;
    logic            r_dp;

    logic [63:0]     w_inputs;
    logic [3:0]      w_nibble;
    logic [6:0]      w_seg;

    assign w_inputs = {PCDisplay, WriteDataDisplay};

    // snap = {PC, WD}: digits 0..3 take WD[15:0], digits 4..7 take PC[15:0]
    always_comb begin
        w_nibble = 4'h0;
        unique case (r_idx)
            3'd0: w_nibble = r_snap[3:0];
            3'd1: w_nibble = r_snap[7:4];
            3'd2: w_nibble = r_snap[11:8];
            3'd3: w_nibble = r_snap[15:12];
            3'd4: w_nibble = r_snap[35:32];
            3'd5: w_nibble = r_snap[39:36];
            3'd6: w_nibble = r_snap[43:40];
            3'd7: w_nibble = r_snap[47:44];
            default: w_nibble = 4'h0;
        endcase
    end

    // Active-low segments, bit 6 = g ... bit 0 = a
    always_comb begin
        w_seg = 7'h7F;
        unique case (w_nibble)
            4'h0: w_seg = 7'h40;
            4'h1: w_seg = 7'h79;
            4'h2: w_seg = 7'h24;
            4'h3: w_seg = 7'h30;
            4'h4: w_seg = 7'h19;
            4'h5: w_seg = 7'h12;
            4'h6: w_seg = 7'h02;
            4'h7: w_seg = 7'h78;
            4'h8: w_seg = 7'h00;
            4'h9: w_seg = 7'h10;
            4'hA: w_seg = 7'h08;
            4'hB: w_seg = 7'h03;
            4'hC: w_seg = 7'h46;
            4'hD: w_seg = 7'h21;
            4'hE: w_seg = 7'h06;
            4'hF: w_seg = 7'h0E;
            default: w_seg = 7'h7F;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_snap    <= '0;
            r_changed <= 1'b0;
            r_cnt     <= '0;
            r_idx     <= 3'd0;
            r_an      <= 8'hFF;
            r_seg     <= 7'h7F;
            r_dp      <= 1'b1;
        end else begin
            // Full 64-bit compare so upper-half-only changes still register
            if (!Hold && (w_inputs != r_snap)) begin
                r_snap    <= w_inputs;
                r_changed <= 1'b1;
            end else begin
                r_changed <= 1'b0;
            end

            if (r_cnt == CntMax) begin
                r_cnt <= '0;
                r_idx <= r_idx + 3'd1;
            end else begin
                r_cnt <= r_cnt + CntW'(1);
            end

            r_an  <= ~(8'd1 << r_idx);
            r_seg <= w_seg;
            r_dp  <= (r_idx != 3'd4);
        end
    end

    assign An      = r_an;
    assign Seg     = r_seg;
    assign Dp      = r_dp;
    assign Changed = r_changed;

endmodule

// File: tb/tb_seg7_debug_display.sv
// Directed bench for seg7_debug_display: a REFRESH_DIV=4 instance for the main scenarios and a
// REFRESH_DIV=1 instance for the fastest scan, sharing all inputs.
module tb_seg7_debug_display;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] PCDisplay;
    logic [31:0] WriteDataDisplay;
    logic        Hold;
    logic [7:0]  An, An1;
    logic [6:0]  Seg, Seg1;
    logic        Dp, Dp1;
    logic        Changed, Changed1;

    int n_vec = 0;
    int n_err = 0;
    int pulses;

    logic [7:0] an_tab  [8];
    logic [6:0] seg_tab [8];

    seg7_debug_display #(.REFRESH_DIV(4)) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .PCDisplay        (PCDisplay),
        .WriteDataDisplay (WriteDataDisplay),
        .Hold             (Hold),
        .An               (An),
        .Seg              (Seg),
        .Dp               (Dp),
        .Changed          (Changed)
    );

    seg7_debug_display #(.REFRESH_DIV(1)) dut1 (
        .Clk              (Clk),
        .Reset            (Reset),
        .PCDisplay        (PCDisplay),
        .WriteDataDisplay (WriteDataDisplay),
        .Hold             (Hold),
        .An               (An1),
        .Seg              (Seg1),
        .Dp               (Dp1),
        .Changed          (Changed1)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        an_tab  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        // Digits 0..7 for PC=0x00400010, WD=0x0000ABCD
        seg_tab = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h40, 7'h79, 7'h40, 7'h40};

        // 1. Reset with arbitrary inputs
        Reset = 1'b1;
        Hold = 1'b0;
        PCDisplay = 32'hDEADBEEF;
        WriteDataDisplay = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            Hold = (i == 1);
            tick();
            check_eq("rst_an", An, 8'hFF);
            check_eq("rst_seg", Seg, 7'h7F);
            check_eq("rst_dp", Dp, 1'b1);
            check_eq("rst_changed", Changed, 1'b0);
            check_eq("rst_an1", An1, 8'hFF);
            check_eq("rst_changed1", Changed1, 1'b0);
        end

        // 2. Basic scan, edges E1..E33; dut1 checked for the fastest scan over E1..E17
        PCDisplay = 32'h00400010;
        WriteDataDisplay = 32'h0000ABCD;
        Hold = 1'b0;
        Reset = 1'b0;
        for (int e = 1; e <= 33; e++) begin
            int d;
            int d1;
            tick();
            d = ((e - 1) / 4) % 8;
            check_eq("scan_an", An, an_tab[d]);
            check_eq("scan_seg", Seg, (e == 1) ? 7'h40 : seg_tab[d]);
            check_eq("scan_dp", Dp, (d == 4) ? 1'b0 : 1'b1);
            check_eq("scan_changed", Changed, (e == 1) ? 1'b1 : 1'b0);
            if (e <= 17) begin
                d1 = (e - 1) % 8;
                check_eq("fast_an", An1, an_tab[d1]);
                check_eq("fast_dp", Dp1, (d1 == 4) ? 1'b0 : 1'b1);
            end
        end

        // 3. Hold freezes the snapshot; release gives one pulse and the new digit 0
        Hold = 1'b1;
        WriteDataDisplay = 32'h00001234;
        for (int e = 34; e <= 36; e++) begin
            tick();
            check_eq("hold_changed", Changed, 1'b0);
            check_eq("hold_an", An, 8'hFE);
            check_eq("hold_seg", Seg, 7'h21);
        end
        Hold = 1'b0;
        pulses = 0;
        for (int e = 37; e <= 65; e++) begin
            tick();
            if (Changed) pulses++;
        end
        check_eq("unhold_pulses", pulses, 1);
        check_eq("unhold_an", An, 8'hFE);
        check_eq("unhold_seg", Seg, 7'h19);

        // 4. Upper-half-only change then constant input: exactly one pulse
        PCDisplay = 32'hABCD0010;
        pulses = 0;
        for (int e = 66; e <= 86; e++) begin
            tick();
            if (Changed) pulses++;
        end
        check_eq("upper_pulses", pulses, 1);
        check_eq("upper_an", An, 8'hDF);
        check_eq("upper_seg", Seg, 7'h79);
        check_eq("upper_dp", Dp, 1'b1);

        // 5. Reset while An=DF, then a fresh scan from digit 0
        Reset = 1'b1;
        PCDisplay = 32'h00000005;
        WriteDataDisplay = 32'h00000007;
        tick();
        check_eq("midrst_an", An, 8'hFF);
        check_eq("midrst_seg", Seg, 7'h7F);
        check_eq("midrst_dp", Dp, 1'b1);
        check_eq("midrst_changed", Changed, 1'b0);
        Reset = 1'b0;
        tick();
        check_eq("restart_an", An, 8'hFE);
        check_eq("restart_seg", Seg, 7'h40);
        check_eq("restart_changed", Changed, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("restart_an_hold", An, 8'hFE);
            check_eq("restart_seg7", Seg, 7'h78);
            check_eq("restart_changed0", Changed, 1'b0);
        end
        tick();
        check_eq("restart_next_an", An, 8'hFD);
        check_eq("restart_next_seg", Seg, 7'h40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
